// File: rtl/freq_synth.sv
// Programmable square-wave generator. A sequential restoring divider turns a
// frequency in Hz into a phase-accumulator tuning word, and clk_out is the accumulator MSB.
module freq_synth #(
  parameter logic [25:0] CLK_FS = 26'd50000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] freq_set,
  input  logic        set_en,
  output logic        busy,
  output logic        done,
  output logic [19:0] freq_cur,
  output logic        clk_out
);
  localparam int unsigned FW = 20;
  localparam int unsigned WW = 32;
  localparam int unsigned NW = FW + WW;
  localparam int unsigned RW = 27;
  localparam int unsigned CW = 6;
  localparam logic [25:0] HALF = CLK_FS >> 1;

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  state_t        state, state_d;
  logic          start_c, step_c, load_c;
  logic [FW-1:0] f_req, f_clamp_c;
  logic [NW-1:0] num;
  logic [RW-1:0] rem, rem_sh_c;
  logic [WW-1:0] quo, word, acc;
  logic [CW-1:0] cnt;
  logic          ge_c;

  // Requests above Nyquist are limited to CLK_FS/2.
  assign f_clamp_c = ({6'd0, freq_set} > HALF) ? FW'(HALF) : freq_set;

  // One restoring step: bring down the next numerator bit, subtract if it fits.
  assign rem_sh_c = RW'({rem, num[NW-1]});
  assign ge_c     = rem_sh_c >= RW'(CLK_FS);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    start_c = 1'b0;
    step_c  = 1'b0;
    load_c  = 1'b0;
    case (state)
      IDLE: begin
        if (set_en) begin
          start_c = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        step_c = 1'b1;
        if (cnt == CW'(NW - 1)) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      freq_cur <= '0;
      f_req    <= '0;
      num      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      word     <= '0;
    end else begin
      done <= 1'b0;
      if (start_c) begin
        busy  <= 1'b1;
        f_req <= f_clamp_c;
        num   <= {f_clamp_c, WW'(0)};
        rem   <= '0;
        quo   <= '0;
        cnt   <= '0;
      end
      if (step_c) begin
        num <= num << 1;
        rem <= ge_c ? rem_sh_c - RW'(CLK_FS) : rem_sh_c;
        quo <= {quo[WW-2:0], ge_c};
        cnt <= cnt + CW'(1);
      end
      if (load_c) begin
        word     <= quo;
        freq_cur <= f_req;
        done     <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

  // A zero word parks the phase at 0 so the next nonzero word starts clean.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc     <= '0;
      clk_out <= 1'b0;
    end else if (word == '0) begin
      acc     <= '0;
      clk_out <= 1'b0;
    end else begin
      acc     <= acc + word;
      clk_out <= acc[WW-1];
    end
  end

endmodule

// File: tb/tb_freq_synth.sv
// Bench for freq_synth: arithmetic reference model compared every cycle, plus
// directed literal checks of tuning words, latency, clamping and reset abort.
module tb_freq_synth;
  localparam longint FS_A = 50000000;

  logic        clk, rst_n;
  logic [19:0] freq_set, freq_cur, freq_set_b, freq_cur_b;
  logic        set_en, busy, done, clk_out;
  logic        set_en_b, busy_b, done_b, clk_out_b;

  int checks = 0;
  int errors = 0;

  freq_synth dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .freq_set(freq_set), .set_en(set_en),
    .busy(busy), .done(done), .freq_cur(freq_cur), .clk_out(clk_out)
  );

  freq_synth #(.CLK_FS(26'd1000000)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .freq_set(freq_set_b), .set_en(set_en_b),
    .busy(busy_b), .done(done_b), .freq_cur(freq_cur_b), .clk_out(clk_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic logic [19:0] clampf(input logic [19:0] f, input longint fs);
    longint fc;
    fc = longint'(f);
    if (fc > fs / 2) fc = fs / 2;
    return 20'(fc);
  endfunction

  function automatic logic [31:0] tune(input logic [19:0] f, input longint fs);
    longint fc;
    fc = longint'(clampf(f, fs));
    return 32'((fc << 32) / fs);
  endfunction

  // Reference model: event times in edges, accumulator as plain modular arithmetic.
  logic [31:0] m_word, m_acc, m_q;
  logic [19:0] m_fcur, m_freq;
  logic        m_clk, m_busy, m_done, m_pend;
  longint      m_edge, m_load_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word = '0; m_acc = '0; m_q = '0; m_fcur = '0; m_freq = '0;
      m_clk = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0;
      m_edge = 0; m_load_edge = 0;
    end else begin
      m_edge++;
      if (m_word == 32'd0) begin
        m_acc = '0;
        m_clk = 1'b0;
      end else begin
        m_clk = m_acc[31];
        m_acc = m_acc + m_word;
      end
      m_done = 1'b0;
      if (m_pend && m_edge == m_load_edge) begin
        m_word = m_q;
        m_fcur = m_freq;
        m_done = 1'b1;
        m_busy = 1'b0;
        m_pend = 1'b0;
      end else if (!m_pend && set_en === 1'b1) begin
        m_freq      = clampf(freq_set, FS_A);
        m_q         = tune(freq_set, FS_A);
        m_pend      = 1'b1;
        m_load_edge = m_edge + 53;
        m_busy      = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("freq_cur", 32'(freq_cur), 32'(m_fcur));
      chk("clk_out", 32'(clk_out), 32'(m_clk));
      chk("word", dut.word, m_word);
    end
  end

  task automatic do_load(input logic [19:0] f, input bit inject, output int nb, output int lat);
    @(negedge clk);
    freq_set = f;
    set_en   = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
    nb  = 0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nb++;
      if (inject && lat == 10) begin
        set_en   = 1'b1;
        freq_set = 20'd1234;
      end else begin
        set_en = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    set_en = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic measure(input int n, output int rises, output int minrun,
                         output int maxrun, output int highs);
    logic prev;
    int   run;
    bit   first;
    prev = clk_out; run = 0; first = 1'b1;
    rises = 0; highs = 0; minrun = 1000000; maxrun = 0;
    repeat (n) begin
      @(negedge clk);
      if (clk_out !== prev) begin
        if (!first) begin
          if (run < minrun) minrun = run;
          if (run > maxrun) maxrun = run;
        end
        first = 1'b0;
        run   = 1;
        if (clk_out === 1'b1) rises++;
      end else begin
        run++;
      end
      if (clk_out === 1'b1) highs++;
      prev = clk_out;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int nb, lat, rises, minrun, maxrun, highs, c, dcount;
    logic [19:0] f;
    logic prev, expn;
    bit inj;

    rst_n = 1'b0; set_en = 1'b0; freq_set = '0;
    set_en_b = 1'b0; freq_set_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_freq_cur", 32'(freq_cur), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    rst_n = 1'b1;

    // 500 kHz: latency, tuning word and waveform shape
    do_load(20'd500000, 1'b0, nb, lat);
    chk("busy_cycles_500k", 32'(nb), 32'd53);
    chk("done_latency_500k", 32'(lat), 32'd54);
    chk("word_500k", dut.word, 32'd42949672);
    chk("freq_cur_500k", 32'(freq_cur), 32'd500000);
    measure(10000, rises, minrun, maxrun, highs);
    chk_range("rises_500k", rises, 99, 101);
    chk_range("minrun_500k", minrun, 49, 51);
    chk_range("maxrun_500k", maxrun, 49, 51);

    // 1 Hz
    do_load(20'd1, 1'b0, nb, lat);
    chk("busy_cycles_1", 32'(nb), 32'd53);
    chk("done_latency_1", 32'(lat), 32'd54);
    chk("word_1", dut.word, 32'd85);
    chk("freq_cur_1", 32'(freq_cur), 32'd1);

    // Running, then stop with 0
    do_load(20'd500000, 1'b0, nb, lat);
    repeat (300) @(negedge clk);
    do_load(20'd0, 1'b0, nb, lat);
    chk("freq_cur_0", 32'(freq_cur), 32'd0);
    measure(1000, rises, minrun, maxrun, highs);
    chk("highs_stopped", 32'(highs), 32'd0);

    // Restart from phase 0 at 1 MHz
    do_load(20'd1000000, 1'b0, nb, lat);
    chk("word_1m", dut.word, 32'd85899345);
    c = 0;
    while (clk_out !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("first_rise_1m", 32'(c), 32'd27);

    // set_en during busy is dropped
    do_load(20'd700000, 1'b1, nb, lat);
    chk("word_700k", dut.word, 32'd60129542);
    chk("freq_cur_700k", 32'(freq_cur), 32'd700000);
    dcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("extra_done", 32'(dcount), 32'd0);

    // Randomized retunes
    repeat (8) begin
      f   = 20'($urandom_range(0, 1048575));
      inj = 1'($urandom_range(0, 1));
      do_load(f, inj, nb, lat);
      chk("busy_cycles_rnd", 32'(nb), 32'd53);
      chk("done_latency_rnd", 32'(lat), 32'd54);
      chk("word_rnd", dut.word, tune(f, FS_A));
      repeat ($urandom_range(20, 400)) @(negedge clk);
    end

    // Reset mid-computation
    do_load(20'd250000, 1'b0, nb, lat);
    repeat (200) @(negedge clk);
    freq_set = 20'd300000;
    set_en   = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_freq_cur", 32'(freq_cur), 32'd0);
    chk("abort_clk_out", 32'(clk_out), 32'd0);
    chk("abort_word", dut.word, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    highs  = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      if (clk_out === 1'b1) highs++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    chk("abort_clk_low", 32'(highs), 32'd0);

    // Clamp at CLK_FS=1 MHz
    @(negedge clk);
    freq_set_b = 20'd600000;
    set_en_b   = 1'b1;
    @(negedge clk);
    set_en_b = 1'b0;
    c = 1;
    while (done_b !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("clamp_done_latency", 32'(c), 32'd54);
    chk("clamp_freq_cur", 32'(freq_cur_b), 32'd500000);
    chk("clamp_word", dut_b.word, 32'h8000_0000);
    repeat (4) @(negedge clk);
    prev = clk_out_b;
    repeat (20) begin
      @(negedge clk);
      expn = !prev;
      chk("clamp_toggle", 32'(clk_out_b), 32'(expn));
      prev = clk_out_b;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_synth.md
# freq_synth

Programmable square-wave generator: the transmit-side counterpart of the equal-precision frequency meter. It turns a requested frequency in Hz (the same 20-bit format the meter reports) into a phase-accumulator tuning word, using an on-block sequential divider. It then drives a square wave on `clk_out` from `sys_clk`. It replaces the fixed-PLL test source, so the meter can be exercised at any frequency up to `CLK_FS/2`.

## Interface
- `CLK_FS`, 26'd50000000: reference clock frequency in Hz, 26-bit.
- `sys_clk` input, 1 bit: reference clock, frequency `CLK_FS`.
- `sys_rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `freq_set` input, 20 bits: requested output frequency in Hz, unsigned.
- `set_en` input, 1 bit: one-cycle load strobe for `freq_set`.
- `busy` output, 1 bit: high while a tuning-word computation is in progress.
- `done` output, 1 bit: one-cycle pulse when the new tuning word takes effect.
- `freq_cur` output, 20 bits: frequency currently applied, after clamping.
- `clk_out` output, 1 bit: generated square wave, registered.

## Operation
- Reset values: `busy`=0, `done`=0, `freq_cur`=0, `clk_out`=0. Internally, tuning word=0, 32-bit accumulator=0, state=IDLE.
- State machine has three states: IDLE, DIV and LOAD.
- IDLE:
  - `set_en`=1 captures `freq_set` into `f_req` and goes to DIV.
  - If `f_req` > `CLK_FS/2` (integer), it is clamped to `CLK_FS/2`.
  - `busy` goes high on the same edge.
- DIV runs a restoring shift-subtract division for exactly 52 cycles:
  - Numerator = `f_req`·2^32 (52 bits). Divisor = `CLK_FS`. Remainder register is 27 bits.
  - One quotient bit per cycle, MSB first.
  - Quotient = floor(`f_req`·2^32/`CLK_FS`). It is at most 2^31 because of the clamp, so 32 bits suffice.
- LOAD, one cycle:
  - Write the quotient to the tuning word and `f_req` to `freq_cur`.
  - Pulse `done`, drop `busy`, return to IDLE.
- `set_en` while `busy`=1 is ignored entirely; there is no queueing.
- Accumulator: acc <= acc + word (mod 2^32) every cycle. `clk_out` <= acc[31] every cycle.
- A retune is phase-continuous: the accumulator is not cleared.
- Tuning word 0 (`freq_set`=0):
  - The accumulator is forced to 0 and `clk_out` is forced to 0 on each cycle while the word is 0.
  - A later nonzero word starts from phase 0.
- The old frequency keeps running unchanged throughout DIV.

## Timing
- `set_en` is sampled at edge E. The edge numbering below follows from that.
- `busy` is high from E+1 through E+53 (53 cycles).
- The DIV cycles occupy edges E+1…E+52.
- At edge E+53, `done`=1 for one cycle, the new word is active, and `freq_cur` is updated.
- At E+54, `done`=0 and `busy`=0. A new `set_en` is accepted at E+54 or later.
- The accumulator uses the new word from edge E+54 onward. `clk_out` reflects it one cycle later (registered MSB).
- Output frequency = word·`CLK_FS`/2^32. Period jitter is ±1 `sys_clk` cycle, and the long-run average is exact to the word.
- Duty cycle is 50% ±1 `sys_clk` cycle.
- Reset asserted mid-DIV aborts the computation. All outputs return to reset values asynchronously, and no `done` is produced.

## Test plan
- Reset, then `freq_set`=500000 with `set_en`:
  - `busy` is high for 53 cycles and `done` pulses at E+53.
  - Word = 42949672, `freq_cur`=500000.
  - Over 10000 cycles, `clk_out` has 100 rising edges (±1), and each high/low phase is 50±1 cycles.
- `freq_set`=1:
  - Word = 85 (floor of 85.899).
  - `freq_cur`=1 and `done` timing is identical.
- Running at 500000, apply `freq_set`=0:
  - After `done`, `clk_out` stays 0 for 1000 cycles and `freq_cur`=0.
  - Then set 1000000: word = 85899345, and the first rising edge of `clk_out` occurs about 25 cycles after the new word takes effect.
- Override `CLK_FS`=1000000, apply `freq_set`=600000:
  - The request is clamped. `freq_cur`=500000 and word = 2^31.
  - `clk_out` toggles every cycle.
- During `busy`, pulse `set_en` with `freq_set`=1234:
  - It is ignored. Only the first value is loaded, and only one `done` pulse occurs.
- Assert `sys_rst_n`=0 at E+20 of a computation:
  - All outputs go to 0 immediately.
  - After release, no `done` appears, and `clk_out` stays 0 until a new load.
